// File: rtl/item_pickup_tracker_if.sv
// Bus between position logic, spawner, score/draw logic and the item pickup tracker.
// The tracker owns the slave side; the game/position logic (or a bench) owns the master side.
interface item_pickup_tracker_if #(
   parameter int N_ITEMS = 4,
   parameter int CTR_W   = 8
);
   logic                  game_restart;
   logic [11:0]           jerry_x;
   logic [11:0]           jerry_y;
   logic [12*N_ITEMS-1:0] item_x;
   logic [12*N_ITEMS-1:0] item_y;
   logic [N_ITEMS-1:0]    item_valid;
   logic [N_ITEMS-1:0]    respawn_ack;
   logic [N_ITEMS-1:0]    taken_pulse;
   logic [N_ITEMS-1:0]    respawn_req;
   logic [CTR_W-1:0]      item_ctr;
   logic                  goal_reached;

   modport master (
      output game_restart, jerry_x, jerry_y, item_x, item_y, item_valid, respawn_ack,
      input  taken_pulse, respawn_req, item_ctr, goal_reached
   );

   modport slave (
      input  game_restart, jerry_x, jerry_y, item_x, item_y, item_valid, respawn_ack,
      output taken_pulse, respawn_req, item_ctr, goal_reached
   );
endinterface

// File: rtl/item_pickup_tracker.sv
// Multi-channel pickup detector: per-item dwell filter, taken pulse, respawn handshake, wrapping score.
// Optional feature macro PICKUP_DWELL_HOLD_EN: lost overlap in DWELL keeps progress instead of restarting.
module item_pickup_tracker #(
   parameter int N_ITEMS      = 4,
   parameter int DWELL_CYCLES = 10000,
   parameter int GOAL         = 10,
   parameter int CTR_W        = 8,
   parameter int ITEM_W       = 20,
   parameter int ITEM_H       = 18,
   parameter int JERRY_W      = 30,
   parameter int JERRY_H      = 30,
   parameter int MARGIN       = 5
) (
   input logic                  clk,
   input logic                  rst,
   item_pickup_tracker_if.slave bus
);
   localparam int DW_W = $clog2(DWELL_CYCLES);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [CTR_W:0]   GOAL_V     = (CTR_W+1)'(GOAL);

   typedef enum logic [1:0] {IDLE, DWELL, TAKEN, RESPAWN} state_t;

   state_t             state_q [N_ITEMS];
   state_t             state_d [N_ITEMS];
   logic [DW_W-1:0]    dwell_q [N_ITEMS];
   logic [DW_W-1:0]    dwell_d [N_ITEMS];
   logic [N_ITEMS-1:0] overlap;
   logic [N_ITEMS-1:0] taken_q, taken_d;
   logic [N_ITEMS-1:0] req_q, req_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic               goal_q, goal_d;
   logic [CTR_W:0]     sum;

   // Strict box intersection against the shrunk item box; touching edges do not count.
   always_comb begin
      overlap = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         overlap[i] =
            ({1'b0, bus.jerry_x} < {1'b0, bus.item_x[12*i +: 12]} + 13'(ITEM_W - MARGIN)) &&
            ({1'b0, bus.jerry_x} + 13'(JERRY_W) > {1'b0, bus.item_x[12*i +: 12]} + 13'(MARGIN)) &&
            ({1'b0, bus.jerry_y} < {1'b0, bus.item_y[12*i +: 12]} + 13'(ITEM_H - MARGIN)) &&
            ({1'b0, bus.jerry_y} + 13'(JERRY_H) > {1'b0, bus.item_y[12*i +: 12]} + 13'(MARGIN));
      end
   end

   always_comb begin
      sum = {1'b0, ctr_q};
      for (int i = 0; i < N_ITEMS; i++) begin
         state_d[i] = state_q[i];
         dwell_d[i] = dwell_q[i];
         case (state_q[i])
            IDLE: begin
               if (bus.item_valid[i] && overlap[i]) begin
                  state_d[i] = DWELL;
                  dwell_d[i] = DW_W'(1);
               end else begin
                  dwell_d[i] = '0;
               end
            end
            DWELL: begin
               if (!bus.item_valid[i]) begin
                  state_d[i] = IDLE;
                  dwell_d[i] = '0;
               end else if (overlap[i]) begin
                  if (dwell_q[i] == DWELL_LAST) begin
                     state_d[i] = TAKEN;
                     dwell_d[i] = '0;
                  end else begin
                     dwell_d[i] = dwell_q[i] + DW_W'(1);
                  end
               end else begin
`ifdef PICKUP_DWELL_HOLD_EN
                  state_d[i] = DWELL;
                  dwell_d[i] = dwell_q[i];
`else
                  state_d[i] = IDLE;
                  dwell_d[i] = '0;
`endif
               end
            end
            TAKEN: begin
               state_d[i] = RESPAWN;
               dwell_d[i] = '0;
            end
            RESPAWN: begin
               if (bus.respawn_ack[i]) begin
                  state_d[i] = IDLE;
               end
               dwell_d[i] = '0;
            end
            default: begin
               state_d[i] = IDLE;
               dwell_d[i] = '0;
            end
         endcase
         taken_d[i] = (state_d[i] == TAKEN);
         req_d[i]   = (state_d[i] == RESPAWN);
         sum        = sum + (CTR_W+1)'(taken_d[i]);
      end

      // Every simultaneous take is summed before the wrap so none is lost.
      if (sum >= GOAL_V) begin
         ctr_d  = CTR_W'(sum - GOAL_V);
         goal_d = 1'b1;
      end else begin
         ctr_d  = CTR_W'(sum);
         goal_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.game_restart) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            state_q[i] <= IDLE;
            dwell_q[i] <= '0;
         end
         taken_q <= '0;
         req_q   <= '0;
         ctr_q   <= '0;
         goal_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N_ITEMS; i++) begin
            state_q[i] <= state_d[i];
            dwell_q[i] <= dwell_d[i];
         end
         taken_q <= taken_d;
         req_q   <= req_d;
         ctr_q   <= ctr_d;
         goal_q  <= goal_d;
      end
   end

   assign bus.taken_pulse  = taken_q;
   assign bus.respawn_req  = req_q;
   assign bus.item_ctr     = ctr_q;
   assign bus.goal_reached = goal_q;

endmodule

// File: tb/tb_item_pickup_tracker.sv
// Directed scoreboard bench for item_pickup_tracker (N_ITEMS=2, DWELL_CYCLES=4, GOAL=3).
// Expected outputs are queued when each step is driven and compared one edge later.
module tb_item_pickup_tracker;
   localparam int N  = 2;
   localparam int CW = 8;

   typedef struct packed {
      logic [N-1:0]  taken;
      logic [N-1:0]  req;
      logic [CW-1:0] ctr;
      logic          goal;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   string tag_q[$];

   item_pickup_tracker_if #(.N_ITEMS(N), .CTR_W(CW)) bus ();

   item_pickup_tracker #(
      .N_ITEMS(N), .DWELL_CYCLES(4), .GOAL(3), .CTR_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Jerry positions: ON0 overlaps item 0 at (100,100), ON1 overlaps item 1 at (300,300).
   localparam logic [11:0] FAR  = 12'd0;
   localparam logic [11:0] ON0  = 12'd100;
   localparam logic [11:0] ON1  = 12'd300;
   localparam logic [11:0] EDGE = 12'd75;

   task automatic applyStimulus(input string tag, input logic r, input logic [11:0] jx,
                                input logic [11:0] jy, input logic [N-1:0] valid,
                                input logic [N-1:0] ack, input logic restart,
                                input logic [N-1:0] e_taken, input logic [N-1:0] e_req,
                                input logic [CW-1:0] e_ctr, input logic e_goal);
      exp_t e;
      rst              = r;
      bus.jerry_x      = jx;
      bus.jerry_y      = jy;
      bus.item_valid   = valid;
      bus.respawn_ack  = ack;
      bus.game_restart = restart;
      e.taken = e_taken;
      e.req   = e_req;
      e.ctr   = e_ctr;
      e.goal  = e_goal;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic checkOutput();
      exp_t  e;
      exp_t  got;
      string tag;
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      got.taken = bus.taken_pulse;
      got.req   = bus.respawn_req;
      got.ctr   = bus.item_ctr;
      got.goal  = bus.goal_reached;
      checks++;
      assert (got === e) else begin
         errors++;
         $error("[TB] FAIL %s observed taken=%b req=%b ctr=%0d goal=%b expected taken=%b req=%b ctr=%0d goal=%b",
                tag, got.taken, got.req, got.ctr, got.goal, e.taken, e.req, e.ctr, e.goal);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic [11:0] jx,
                       input logic [11:0] jy, input logic [N-1:0] valid,
                       input logic [N-1:0] ack, input logic restart,
                       input logic [N-1:0] e_taken, input logic [N-1:0] e_req,
                       input logic [CW-1:0] e_ctr, input logic e_goal);
      applyStimulus(tag, r, jx, jy, valid, ack, restart, e_taken, e_req, e_ctr, e_goal);
      checkOutput();
   endtask

   task automatic setItems(input logic [11:0] x1, input logic [11:0] y1);
      bus.item_x = {x1, 12'd100};
      bus.item_y = {y1, 12'd100};
   endtask

   initial begin
      setItems(12'd300, 12'd300);
      bus.jerry_x = FAR; bus.jerry_y = FAR;
      bus.item_valid = '0; bus.respawn_ack = '0; bus.game_restart = 1'b0;

      step("reset", 1, FAR, FAR, 2'b00, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);

      // Reset mid-dwell must discard accumulated progress.
      step("t1_dwell1", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);
      step("t1_dwell2", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);
      step("t1_rst",    1, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);
      for (int i = 0; i < 3; i++)
         step("t1_fresh", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);
      step("t1_invalid", 0, FAR, FAR, 2'b00, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);

      // Single take, respawn handshake, stray ack ignored in IDLE.
      for (int i = 0; i < 3; i++)
         step("t2_dwell", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);
      step("t2_taken",  0, ON0, ON0, 2'b11, 2'b00, 0, 2'b01, 2'b00, 8'd1, 0);
      for (int i = 0; i < 3; i++)
         step("t2_req_held", 0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b01, 8'd1, 0);
      step("t2_ack",    0, FAR, FAR, 2'b11, 2'b01, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t2_ack_idle", 0, FAR, FAR, 2'b11, 2'b01, 0, 2'b00, 2'b00, 8'd1, 0);

      // Broken overlap: default restarts the dwell, hold mode resumes it.
      step("t3_on_a", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t3_on_b", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t3_gap",  0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t3_on_c", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
`ifdef PICKUP_DWELL_HOLD_EN
      step("t3_hold_take", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b01, 2'b00, 8'd2, 0);
      step("t3_hold_req",  0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b01, 8'd2, 0);
      step("t3_hold_ack",  0, FAR, FAR, 2'b11, 2'b01, 0, 2'b00, 2'b00, 8'd2, 0);
`else
      step("t3_no_take",   0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t3_after",     0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      for (int i = 0; i < 3; i++)
         step("t3_ch1_dwell", 0, ON1, ON1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t3_ch1_take",  0, ON1, ON1, 2'b11, 2'b00, 0, 2'b10, 2'b00, 8'd2, 0);
      step("t3_ch1_req",   0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b10, 8'd2, 0);
      step("t3_ch1_ack",   0, FAR, FAR, 2'b11, 2'b10, 0, 2'b00, 2'b00, 8'd2, 0);
`endif

      // Two simultaneous takes from ctr=2 cross GOAL=3 and wrap to 1.
      setItems(12'd100, 12'd100);
      for (int i = 0; i < 3; i++)
         step("t4_dwell", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd2, 0);
      step("t4_goal",  0, ON0, ON0, 2'b11, 2'b00, 0, 2'b11, 2'b00, 8'd1, 1);
      step("t4_req",   0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b11, 8'd1, 0);
      step("t4_ack",   0, FAR, FAR, 2'b11, 2'b11, 0, 2'b00, 2'b00, 8'd1, 0);
      setItems(12'd300, 12'd300);

      // Jerry's right edge exactly on the shrunk item's left edge is not an overlap.
      for (int i = 0; i < 10; i++)
         step("t5_edge", 0, EDGE, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);

      // Overlap in RESPAWN without ack is ignored; game_restart clears everything.
      for (int i = 0; i < 3; i++)
         step("t6_dwell", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd1, 0);
      step("t6_take", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b01, 2'b00, 8'd2, 0);
      for (int i = 0; i < 20; i++)
         step("t6_respawn_hold", 0, ON0, ON0, 2'b11, 2'b00, 0, 2'b00, 2'b01, 8'd2, 0);
      step("t6_restart", 0, ON0, ON0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 8'd0, 0);
      step("t6_post",    0, FAR, FAR, 2'b11, 2'b00, 0, 2'b00, 2'b00, 8'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
